// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in and response-out handshake bundle for alu_issue_ctrl.
// master = upstream issuer / downstream consumer side, slave = the controller.
interface alu_issue_ctrl_if #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [4:0]           in_opcode;
   logic [BITS_DATA-1:0] in_a;
   logic [BITS_DATA-1:0] in_b;
   logic [BITS_ADDR-1:0] in_target;
   logic                 res_valid;
   logic                 res_ready;
   logic [BITS_DATA-1:0] res_data;
   logic                 jmp_taken;
   logic [BITS_ADDR-1:0] jmp_addr;

   modport master (
      output in_valid, in_opcode, in_a, in_b, in_target, res_ready,
      input  in_ready, res_valid, res_data, jmp_taken, jmp_addr
   );

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, in_target, res_ready,
      output in_ready, res_valid, res_data, jmp_taken, jmp_addr
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: drives the combinational ALU, keeps {C,S,O,Z}, resolves jumps.
// Optional retired-instruction counter is built only when ALU_CTRL_RETIRE_CNT_EN is defined.
module alu_issue_ctrl #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_issue_ctrl_if.slave      bus,
   output logic [4:0]           alu_opcode,
   output logic [BITS_DATA-1:0] alu_operando_a,
   output logic [BITS_DATA-1:0] alu_operando_b,
   input  logic [BITS_DATA-1:0] alu_resultado,
   input  logic                 alu_C,
   input  logic                 alu_S,
   input  logic                 alu_O,
   input  logic                 alu_Z,
   output logic [3:0]           flags,
   output logic                 illegal_op,
   output logic                 halted,
   output logic [31:0]          retire_cnt
);

   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_NOT = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4;
   localparam logic [4:0] OP_NEG = 5'd5;
   localparam logic [4:0] OP_ADD = 5'd6;
   localparam logic [4:0] OP_SUB = 5'd7;
   localparam logic [4:0] OP_MUL = 5'd8;
   localparam logic [4:0] OP_DIV = 5'd9;
   localparam logic [4:0] OP_MOD = 5'd10;
   localparam logic [4:0] OP_JMP = 5'd11;
   localparam logic [4:0] OP_JC  = 5'd12;
   localparam logic [4:0] OP_JS  = 5'd13;
   localparam logic [4:0] OP_JO  = 5'd14;
   localparam logic [4:0] OP_JZ  = 5'd15;
   localparam logic [4:0] OP_HLT = 5'd31;

   typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;

   state_t               state, state_nxt;
   logic [4:0]           op_p0;
   logic [BITS_DATA-1:0] a_p0, b_p0;
   logic [BITS_ADDR-1:0] tgt_p0;
   logic [BITS_DATA-1:0] res_p1;
   logic                 jmp_p1;
   logic [BITS_ADDR-1:0] addr_p1;
   logic [3:0]           flags_q;
   logic                 halted_q;
   logic                 capture, load_alu, load_jmp, set_halt, taken;

   function automatic logic is_alu_op(input logic [4:0] op);
      case (op)
         OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NEG,
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   function automatic logic is_jump(input logic [4:0] op);
      return (op >= OP_JMP) && (op <= OP_JZ);
   endfunction

   // Conditions test the flag register as it stood before this jump
   function automatic logic jump_taken(input logic [4:0] op, input logic [3:0] f);
      case (op)
         OP_JMP:  return 1'b1;
         OP_JC:   return f[3];
         OP_JS:   return f[2];
         OP_JO:   return f[1];
         OP_JZ:   return f[0];
         default: return 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      load_alu   = 1'b0;
      load_jmp   = 1'b0;
      set_halt   = 1'b0;
      illegal_op = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               capture   = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (is_alu_op(op_p0)) begin
               load_alu  = 1'b1;
               state_nxt = RESP;
            end else if (is_jump(op_p0)) begin
               load_jmp  = 1'b1;
               state_nxt = RESP;
            end else if (op_p0 == OP_NOP) begin
               state_nxt = IDLE;
            end else if (op_p0 == OP_HLT) begin
               set_halt  = 1'b1;
               state_nxt = HALT;
            end else begin
               illegal_op = 1'b1;
               state_nxt  = IDLE;
            end
         end
         RESP: begin
            if (bus.res_ready) state_nxt = IDLE;
         end
         HALT: state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   assign taken = jump_taken(op_p0, flags_q);

   // Stage p0: captured instruction, held through EXEC and beyond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_p0  <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
         tgt_p0 <= '0;
      end else if (capture) begin
         op_p0  <= bus.in_opcode;
         a_p0   <= bus.in_a;
         b_p0   <= bus.in_b;
         tgt_p0 <= bus.in_target;
      end
   end

   // Stage p1: response registers and architectural flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p1   <= '0;
         jmp_p1   <= 1'b0;
         addr_p1  <= '0;
         flags_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         if (load_alu) begin
            res_p1  <= alu_resultado;
            jmp_p1  <= 1'b0;
            addr_p1 <= '0;
            flags_q <= {alu_C, alu_S, alu_O, alu_Z};
         end else if (load_jmp) begin
            res_p1  <= '0;
            jmp_p1  <= taken;
            addr_p1 <= taken ? tgt_p0 : '0;
         end
         if (set_halt) halted_q <= 1'b1;
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.res_valid  = (state == RESP);
   assign bus.res_data   = res_p1;
   assign bus.jmp_taken  = jmp_p1;
   assign bus.jmp_addr   = addr_p1;
   assign alu_opcode     = op_p0;
   assign alu_operando_a = a_p0;
   assign alu_operando_b = b_p0;
   assign flags          = flags_q;
   assign halted         = halted_q;

`ifdef ALU_CTRL_RETIRE_CNT_EN
   logic        retire_inc;
   logic [31:0] retire_q;

   // Responses retire on the handshake; NOP and HLT retire as they leave EXEC
   assign retire_inc = ((state == RESP) && bus.res_ready) ||
                       ((state == EXEC) && ((op_p0 == OP_NOP) || (op_p0 == OP_HLT)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          retire_q <= '0;
      else if (retire_inc) retire_q <= retire_q + 32'd1;
   end

   assign retire_cnt = retire_q;
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and issue model.
// Exercises the retire counter as well when built with ALU_CTRL_RETIRE_CNT_EN.
module tb_alu_issue_ctrl;

   localparam logic [4:0] OP_NOP = 5'd0,  OP_NOT = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4,  OP_NEG = 5'd5,  OP_ADD = 5'd6,  OP_SUB = 5'd7;
   localparam logic [4:0] OP_MUL = 5'd8,  OP_DIV = 5'd9,  OP_MOD = 5'd10, OP_JMP = 5'd11;
   localparam logic [4:0] OP_JC  = 5'd12, OP_JS  = 5'd13, OP_JO  = 5'd14, OP_JZ  = 5'd15;
   localparam logic [4:0] OP_LD  = 5'd16, OP_STR = 5'd17, OP_HLT = 5'd31;

`ifdef ALU_CTRL_RETIRE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  alu_opcode;
   logic [31:0] alu_a, alu_b, alu_res;
   logic        alu_c, alu_s, alu_o, alu_z;
   logic [3:0]  flags;
   logic        illegal_op, halted;
   logic [31:0] retire_cnt;

   int          checks = 0;
   int          failures = 0;
   logic [3:0]  flags_m = 4'b0;
   logic [31:0] retire_m = 32'd0;

   alu_issue_ctrl_if #(.BITS_DATA(32), .BITS_ADDR(8)) bus ();

   alu_issue_ctrl #(.BITS_DATA(32), .BITS_ADDR(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .alu_opcode     (alu_opcode),
      .alu_operando_a (alu_a),
      .alu_operando_b (alu_b),
      .alu_resultado  (alu_res),
      .alu_C          (alu_c),
      .alu_S          (alu_s),
      .alu_O          (alu_o),
      .alu_Z          (alu_z),
      .flags          (flags),
      .illegal_op     (illegal_op),
      .halted         (halted),
      .retire_cnt     (retire_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {result, C, S, O, Z}
   function automatic logic [35:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] t;
      logic [31:0] r;
      logic        c, o;
      r = 32'd0; c = 1'b0; o = 1'b0;
      case (op)
         OP_NOT: r = ~a;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NEG: r = -a;
         OP_ADD: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32]; o = (a[31] == b[31]) && (r[31] != a[31]); end
         OP_SUB: begin t = {1'b0, a} - {1'b0, b}; r = t[31:0]; c = t[32]; o = (a[31] != b[31]) && (r[31] != a[31]); end
         OP_MUL: r = a * b;
         OP_DIV: r = (b == 0) ? 32'd0 : a / b;
         OP_MOD: r = (b == 0) ? 32'd0 : a % b;
         default: r = 32'd0;
      endcase
      return {r, c, r[31], o, (r == 32'd0)};
   endfunction

   always_comb {alu_res, alu_c, alu_s, alu_o, alu_z} = alu_ref(alu_opcode, alu_a, alu_b);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Offers one instruction in IDLE and returns at the falling edge inside EXEC, inputs scrambled
   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b; bus.in_target = t;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_opcode = 5'($urandom); bus.in_a = $urandom; bus.in_b = $urandom;
      bus.in_target = 8'($urandom);
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({bus.in_ready, bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags, illegal_op, halted,
           retire_cnt, alu_opcode, alu_a, alu_b} !== {1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0,
           32'd0, 5'd0, 32'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_state: in_ready=%b res_valid=%b res_data=%h flags=%b alu_op=%0d alu_a=%h retire=%0d required in_ready=1 all others 0",
                  bus.in_ready, bus.res_valid, bus.res_data, flags, alu_opcode, alu_a, retire_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.res_valid} !== 2'b10) begin
         failures++;
         $display("FAIL idle_after_reset: in_ready/res_valid=%b required 10", {bus.in_ready, bus.res_valid});
      end
   endtask

   task automatic test_add_carry;
      send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 8'h00);
      checks++;
      if ({bus.in_ready, bus.res_valid, alu_opcode, alu_a, alu_b} !== {1'b0, 1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1}) begin
         failures++;
         $display("FAIL add_exec: in_ready=%b res_valid=%b alu_op=%0d a=%h b=%h required 0 0 %0d ffffffff 00000001",
                  bus.in_ready, bus.res_valid, alu_opcode, alu_a, alu_b, OP_ADD);
      end
      @(negedge clk);
      flags_m = 4'b1001;
      checks++;
      if ({bus.res_valid, bus.res_data, bus.jmp_taken, flags} !== {1'b1, 32'd0, 1'b0, flags_m}) begin
         failures++;
         $display("FAIL add_resp: res_valid=%b data=%h jmp=%b flags=%b required 1 00000000 0 %b",
                  bus.res_valid, bus.res_data, bus.jmp_taken, flags, flags_m);
      end
      retire_m++;
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.in_ready, retire_cnt} !== {1'b0, 1'b1, (CNT_EN ? retire_m : 32'd0)}) begin
         failures++;
         $display("FAIL add_done: res_valid=%b in_ready=%b retire=%0d required 0 1 %0d",
                  bus.res_valid, bus.in_ready, retire_cnt, CNT_EN ? retire_m : 32'd0);
      end
   endtask

   task automatic test_jumps;
      send(OP_JZ, 32'h1234, 32'h5678, 8'h20);
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags} !== {1'b1, 32'd0, 1'b1, 8'h20, 4'b1001}) begin
         failures++;
         $display("FAIL jz_taken: valid=%b data=%h taken=%b addr=%h flags=%b required 1 0 1 20 1001",
                  bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags);
      end
      retire_m++;
      send(OP_JS, 32'h0, 32'h0, 8'h40);
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags} !== {1'b1, 32'd0, 1'b0, 8'h00, 4'b1001}) begin
         failures++;
         $display("FAIL js_not_taken: valid=%b data=%h taken=%b addr=%h flags=%b required 1 0 0 00 1001",
                  bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags);
      end
      retire_m++;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      bus.res_ready = 1'b0;
      send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 8'h00);
      @(negedge clk);
      flags_m = 4'b0110;
      bus.in_valid = 1'b1; bus.in_opcode = OP_NOT;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.res_valid, bus.res_data, bus.jmp_taken, bus.in_ready, flags} !== {1'b1, 32'h8000_0000, 1'b0, 1'b0, flags_m}) begin
            failures++;
            $display("FAIL stall_hold[%0d]: valid=%b data=%h in_ready=%b flags=%b required 1 80000000 0 %b",
                     i, bus.res_valid, bus.res_data, bus.in_ready, flags, flags_m);
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.res_ready = 1'b1;
      retire_m++;
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.in_ready, alu_opcode, retire_cnt} !== {1'b0, 1'b1, OP_ADD, (CNT_EN ? retire_m : 32'd0)}) begin
         failures++;
         $display("FAIL stall_release: valid=%b in_ready=%b alu_op=%0d retire=%0d required 0 1 %0d %0d",
                  bus.res_valid, bus.in_ready, alu_opcode, retire_cnt, OP_ADD, CNT_EN ? retire_m : 32'd0);
      end
   endtask

   task automatic test_illegal;
      send(OP_LD, 32'h1, 32'h2, 8'h3);
      checks++;
      if (illegal_op !== 1'b1) begin
         failures++;
         $display("FAIL illegal_pulse: illegal_op=%b required 1", illegal_op);
      end
      @(negedge clk);
      checks++;
      if ({illegal_op, bus.res_valid, bus.in_ready, flags, retire_cnt} !== {1'b0, 1'b0, 1'b1, flags_m, (CNT_EN ? retire_m : 32'd0)}) begin
         failures++;
         $display("FAIL illegal_after: illegal=%b valid=%b in_ready=%b flags=%b retire=%0d required 0 0 1 %b %0d",
                  illegal_op, bus.res_valid, bus.in_ready, flags, retire_cnt, flags_m, CNT_EN ? retire_m : 32'd0);
      end
   endtask

   task automatic test_random;
      logic [4:0]  pool [19] = '{OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NEG, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                                 OP_JMP, OP_JC, OP_JS, OP_JO, OP_JZ, OP_NOP, OP_LD, OP_STR, 5'd23};
      logic [4:0]  op;
      logic [31:0] a, b, exp_res;
      logic [7:0]  t, exp_addr;
      logic [35:0] ref_v;
      logic        resp, ill, tk;
      int          stall;
      for (int n = 0; n < 60; n++) begin
         op = pool[$urandom_range(0, 18)];
         a  = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom);
         b  = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
         t  = 8'($urandom);
         stall = $urandom_range(0, 2);
         bus.res_ready = (stall == 0);
         ref_v = alu_ref(op, a, b);
         resp = (op >= OP_NOT && op <= OP_JZ);
         ill  = !resp && (op != OP_NOP);
         tk   = (op == OP_JMP) || (op == OP_JC && flags_m[3]) || (op == OP_JS && flags_m[2]) ||
                (op == OP_JO && flags_m[1]) || (op == OP_JZ && flags_m[0]);
         exp_res  = (op <= OP_MOD) ? ref_v[35:4] : 32'd0;
         exp_addr = tk ? t : 8'd0;
         send(op, a, b, t);
         checks++;
         if ({alu_opcode, alu_a, alu_b, illegal_op, bus.in_ready} !== {op, a, b, ill, 1'b0}) begin
            failures++;
            $display("FAIL rnd_exec[%0d]: op=%0d a=%h b=%h ill=%b rdy=%b required %0d %h %h %b 0",
                     n, alu_opcode, alu_a, alu_b, illegal_op, bus.in_ready, op, a, b, ill);
         end
         @(negedge clk);
         if (op >= OP_NOT && op <= OP_MOD) flags_m = ref_v[3:0];
         if (op == OP_NOP) retire_m++;
         if (resp) begin
            for (int j = 0; j <= stall; j++) begin
               if (j == stall) bus.res_ready = 1'b1;
               checks++;
               if ({bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags} !==
                   {1'b1, exp_res, (op >= OP_JMP) && tk, exp_addr, flags_m}) begin
                  failures++;
                  $display("FAIL rnd_resp[%0d.%0d] op=%0d: valid=%b data=%h taken=%b addr=%h flags=%b required 1 %h %b %h %b",
                           n, j, op, bus.res_valid, bus.res_data, bus.jmp_taken, bus.jmp_addr, flags,
                           exp_res, (op >= OP_JMP) && tk, exp_addr, flags_m);
               end
               @(negedge clk);
            end
            retire_m++;
         end
         checks++;
         if ({bus.res_valid, bus.in_ready, flags, retire_cnt} !== {1'b0, 1'b1, flags_m, (CNT_EN ? retire_m : 32'd0)}) begin
            failures++;
            $display("FAIL rnd_idle[%0d] op=%0d: valid=%b rdy=%b flags=%b retire=%0d required 0 1 %b %0d",
                     n, op, bus.res_valid, bus.in_ready, flags, retire_cnt, flags_m, CNT_EN ? retire_m : 32'd0);
         end
      end
      bus.res_ready = 1'b1;
   endtask

   task automatic test_halt;
      send(OP_HLT, 32'h0, 32'h0, 8'h0);
      checks++;
      if (illegal_op !== 1'b0) begin
         failures++;
         $display("FAIL hlt_not_illegal: illegal_op=%b required 0", illegal_op);
      end
      @(negedge clk);
      retire_m++;
      checks++;
      if ({halted, bus.in_ready, bus.res_valid, retire_cnt} !== {1'b1, 1'b0, 1'b0, (CNT_EN ? retire_m : 32'd0)}) begin
         failures++;
         $display("FAIL hlt_state: halted=%b rdy=%b valid=%b retire=%0d required 1 0 0 %0d",
                  halted, bus.in_ready, bus.res_valid, retire_cnt, CNT_EN ? retire_m : 32'd0);
      end
      bus.in_valid = 1'b1; bus.in_opcode = OP_ADD; bus.in_a = 32'h5; bus.in_b = 32'h6;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({halted, bus.in_ready, bus.res_valid, alu_opcode} !== {1'b1, 1'b0, 1'b0, OP_HLT}) begin
            failures++;
            $display("FAIL hlt_ignore[%0d]: halted=%b rdy=%b valid=%b alu_op=%0d required 1 0 0 %0d",
                     i, halted, bus.in_ready, bus.res_valid, alu_opcode, OP_HLT);
         end
      end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      flags_m = 4'b0; retire_m = 32'd0;
      #1;
      checks++;
      if ({halted, bus.in_ready, flags, alu_opcode} !== {1'b0, 1'b1, 4'b0, 5'd0}) begin
         failures++;
         $display("FAIL hlt_reset: halted=%b rdy=%b flags=%b alu_op=%0d required 0 1 0000 0",
                  halted, bus.in_ready, flags, alu_opcode);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_exec;
      send(OP_ADD, 32'h0, 32'h0, 8'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (flags !== 4'b0001) begin
         failures++;
         $display("FAIL pre_abort_flags: flags=%b required 0001", flags);
      end
      send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 8'h0);
      #2 rst_n = 1'b0;
      flags_m = 4'b0; retire_m = 32'd0;
      #1;
      checks++;
      if ({bus.in_ready, bus.res_valid, bus.res_data, flags, alu_opcode, alu_a, halted, illegal_op, retire_cnt} !==
          {1'b1, 1'b0, 32'd0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL abort_exec: rdy=%b valid=%b data=%h flags=%b alu_op=%0d a=%h retire=%0d required 1 0 0 0000 0 0 0",
                  bus.in_ready, bus.res_valid, bus.res_data, flags, alu_opcode, alu_a, retire_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.res_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL abort_no_resp[%0d]: valid/rdy=%b required 01", i, {bus.res_valid, bus.in_ready});
         end
      end
   endtask

`ifdef ALU_CTRL_RETIRE_CNT_EN
   task automatic test_retire_wrap;
      @(negedge clk);
      force dut.retire_q = 32'hFFFF_FFFE;
      #1 release dut.retire_q;
      send(OP_NOP, 32'h0, 32'h0, 8'h0);
      @(negedge clk);
      checks++;
      if (retire_cnt !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL retire_pre_wrap: retire=%h required ffffffff", retire_cnt);
      end
      send(OP_SUB, 32'h3, 32'h1, 8'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (retire_cnt !== 32'h0) begin
         failures++;
         $display("FAIL retire_wrap: retire=%h required 00000000", retire_cnt);
      end
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0; bus.in_opcode = 5'd0; bus.in_a = 32'd0; bus.in_b = 32'd0;
      bus.in_target = 8'd0; bus.res_ready = 1'b1;
      test_reset;
      test_add_carry;
      test_jumps;
      test_backpressure;
      test_illegal;
      test_random;
      test_halt;
      test_reset_mid_exec;
`ifdef ALU_CTRL_RETIRE_CNT_EN
      test_retire_wrap;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
